// File: rtl/updn_counter_pkg.sv
// Shared constants and types for the up/down counter: terminal-behaviour modes
// and the legal parameter ranges.
package updn_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'd0,
        MODE_SAT    = 2'd1,
        MODE_RELOAD = 2'd2
    } mode_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    // Largest count value for a given width, widened so WIDTH=32 does not overflow.
    function automatic longint unsigned max_count(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/updn_counter_next.sv
// Combinational next-count and terminal-event computation for one enabled,
// non-load edge. Load and enable priority are resolved by the parent.
module updn_counter_next
    import updn_counter_pkg::*;
#(
    parameter int unsigned           WIDTH      = 8,
    parameter logic [WIDTH-1:0]      RELOAD_VAL = '0,
    parameter mode_e                 MODE       = MODE_RELOAD,
    parameter int unsigned           STEP       = 1
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_V  = '1;

    logic             up;
    logic             down;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   diff_x;
    logic             overflow;
    logic             underflow;

    assign up   = inc_i & ~dec_i;
    assign down = dec_i & ~inc_i;

    // One extra bit holds the carry or borrow, so crossing either limit is exact.
    assign sum_x     = {1'b0, count_i} + STEP_X;
    assign diff_x    = {1'b0, count_i} - STEP_X;
    assign overflow  = sum_x[WIDTH];
    assign underflow = diff_x[WIDTH];

    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch is inferred.
        count_o = count_i;
        tc_o    = 1'b0;

        if (MODE == MODE_RELOAD && count_i == MAX_V) begin
            count_o = RELOAD_VAL;
            tc_o    = 1'b1;
        end else if (up) begin
            unique case (MODE)
                MODE_WRAP: begin
                    count_o = sum_x[WIDTH-1:0];
                    tc_o    = overflow;
                end
                MODE_SAT: begin
                    count_o = overflow ? MAX_V : sum_x[WIDTH-1:0];
                    tc_o    = overflow;
                end
                default: begin
                    count_o = overflow ? MAX_V : sum_x[WIDTH-1:0];
                end
            endcase
        end else if (down) begin
            unique case (MODE)
                MODE_WRAP: begin
                    count_o = diff_x[WIDTH-1:0];
                    tc_o    = underflow;
                end
                MODE_SAT: begin
                    count_o = underflow ? '0 : diff_x[WIDTH-1:0];
                    tc_o    = underflow;
                end
                default: begin
                    count_o = underflow ? '0 : diff_x[WIDTH-1:0];
                end
            endcase
        end
    end

endmodule

// File: rtl/updn_counter.sv
// Up/down counter with wrap, saturate or reload terminal behaviour.
// Define UPDN_COUNTER_IRQ_EN to add the sticky irq output and its irq_clr input.
module updn_counter
    import updn_counter_pkg::*;
#(
    parameter int unsigned  WIDTH     = 8,
    parameter logic [31:0]  RESET_VAL = 32'h6A,
    parameter mode_e        MODE      = MODE_RELOAD,
    parameter int unsigned  STEP      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDN_COUNTER_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc
);

    localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("updn_counter: WIDTH %0d outside 2..32", WIDTH);
    end
    if (MODE != MODE_WRAP && MODE != MODE_SAT && MODE != MODE_RELOAD) begin : g_bad_mode
        $error("updn_counter: illegal MODE %0d", MODE);
    end
    if (STEP < 1 || 64'(STEP) > max_count(WIDTH)) begin : g_bad_step
        $error("updn_counter: STEP %0d outside 1..2^WIDTH-1", STEP);
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic [WIDTH-1:0] step_count;
    logic             step_tc;

    updn_counter_next #(
        .WIDTH      (WIDTH),
        .RELOAD_VAL (RST_V),
        .MODE       (MODE),
        .STEP       (STEP)
    ) u_next (
        .count_i (count_q),
        .inc_i   (inc),
        .dec_i   (dec),
        .count_o (step_count),
        .tc_o    (step_tc)
    );

    // Load beats enable; a disabled edge holds and suppresses any terminal event.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = step_count;
            tc_d    = step_tc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_V;
            tc_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign at_max = (count_q == '1);
    assign at_min = (count_q == '0);

`ifdef UPDN_COUNTER_IRQ_EN
    logic irq_q;
    logic irq_d;

    // A pending terminal pulse wins over a simultaneous clear.
    always_comb begin
        irq_d = irq_q;
        if (tc_q) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: doc/updn_counter.md
UPDN_COUNTER -- requirements
Module: updn_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 Parameter RESET_VAL, default 8'h6A, value loaded at reset and by a RELOAD-mode terminal event; truncated to WIDTH.
REQ-003 Parameter MODE, default MODE_RELOAD, terminal behaviour: MODE_WRAP, MODE_SAT or MODE_RELOAD.
REQ-004 Parameter STEP, default 1, increment/decrement magnitude (legal range 1..2^WIDTH-1).
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  count enable; when low, inc/dec and terminal reload are ignored.
REQ-008 inc  input  1  count-up request.
REQ-009 dec  input  1  count-down request.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value written on load.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 at_max  output  1  high while count == 2^WIDTH-1; decoded from the count register.
REQ-014 at_min  output  1  high while count == 0; decoded from the count register.
REQ-015 tc  output  1  registered one-cycle terminal-event pulse.

Function
REQ-016 Per-edge priority SHALL be: load, then en low (hold), then terminal reload, then inc/dec.
REQ-017 load=1 SHALL set count to load_val and tc to 0, regardless of en, inc, dec and MODE.
REQ-018 en=0 with load=0 SHALL hold count and drive tc to 0.
REQ-019 inc=dec=1 or inc=dec=0 SHALL hold count, except for a RELOAD terminal event (REQ-023).
REQ-020 Up/down arithmetic SHALL use WIDTH+1 bits internally, so overflow and underflow are detected exactly.
REQ-021 MODE_WRAP: results SHALL be taken modulo 2^WIDTH; tc=1 on any edge whose result crossed MAX->0 or 0->MAX.
REQ-022 MODE_SAT: up past MAX SHALL clamp to MAX and down below 0 SHALL clamp to 0; tc=1 on every edge where clamping occurred, including while already at the limit.
REQ-023 MODE_RELOAD: with en=1 and count==MAX, the next edge SHALL load RESET_VAL and set tc=1, independent of inc/dec.
REQ-024 MODE_RELOAD: inc from count > MAX-STEP SHALL go to MAX with tc=0; dec from count < STEP SHALL clamp to 0 with tc=0.
REQ-025 tc SHALL be registered together with the count value that the event produced, and SHALL be 0 on all other edges.

Reset
REQ-026 While rst_n=0: count=RESET_VAL, tc=0, and irq=0 when present; at_max and at_min follow count.
REQ-027 Reset asserted mid-operation SHALL override any load or count in progress immediately, without waiting for a clock edge.
REQ-028 After deassertion, the first rising edge SHALL perform normal REQ-016 evaluation.

Configuration
REQ-029 Macro UPDN_COUNTER_IRQ_EN defined: add port irq_clr (input, 1) and irq (output, 1, registered); irq sets on the edge after tc=1 and is sticky until irq_clr=1; if set and clear coincide, set SHALL win.
REQ-030 Macro UPDN_COUNTER_IRQ_EN undefined: irq and irq_clr SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package updn_counter_pkg SHALL hold the MODE_WRAP=0, MODE_SAT=1 and MODE_RELOAD=2 constants and the mode typedef.
REQ-032 Sub-module updn_counter_next SHALL hold the combinational next-value and tc computation; the top SHALL hold the registers, priority logic and optional irq.
REQ-033 An illegal MODE, WIDTH or STEP SHALL raise an elaboration-time error.

Verification (WIDTH=8, RESET_VAL=0x6A, STEP=1 unless stated)
REQ-034 Reset: hold rst_n=0 for 3 cycles -> count=0x6A, tc=0, at_max=0, at_min=0.
REQ-035 RELOAD: load 0xFE, then en=1 and inc=1 for 2 edges -> count 0xFF (at_max=1), then 0x6A with tc=1 for exactly one cycle.
REQ-036 WRAP: load 0x00, then dec=1 for 1 edge -> count=0xFF, tc=1; with STEP=3, load 0xFE and inc -> count=0x01, tc=1.
REQ-037 SAT: load 0xFF, then inc=1 for 3 edges -> count stays 0xFF and tc=1 on each edge; load 0x00 and dec -> count=0x00, tc=1.
REQ-038 Hold cases: from 0x10, inc=dec=1 for 5 edges -> 0x10; en=0 with inc=1 -> 0x10; load and inc on the same edge with load_val=0x33 -> 0x33.
REQ-039 IRQ (UPDN_COUNTER_IRQ_EN defined): a tc event -> irq=1 persists; irq_clr=1 -> irq=0 next edge; irq_clr coinciding with a new set -> irq stays 1; asynchronous reset mid-count -> count=0x6A and irq=0 immediately.
